riscv_test_monitor: RTL and testbench

//  Synthesizable pass/fail monitor for the open_risc_v_soc compliance flow (rv32ui-p-*).

---
 rtl/riscv_tb_pkg.sv | 14 +
 rtl/mon_sat_counter.sv | 23 ++
 rtl/riscv_test_monitor.sv | 121 ++++++++++++
 tb/tb_riscv_test_monitor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_tb_pkg.sv
// rtl/riscv_tb_pkg.sv - shared constants and FSM encoding for the compliance pass/fail monitor
package riscv_tb_pkg;

  localparam int XLEN     = 32;
  localparam int REG_DONE = 26;
  localparam int REG_PASS = 27;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } mon_state_t;

endpackage

// File: rtl/mon_sat_counter.sv
// rtl/mon_sat_counter.sv - up-counter with synchronous clear that holds at all-ones
module mon_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // clear wins over enable so a fresh window always starts from zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// rtl/riscv_test_monitor.sv - snoops register write-back for done/pass flags and latches a sticky verdict
module riscv_test_monitor
  import riscv_tb_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 50,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DONE_REG       = REG_DONE,
  parameter int PASS_REG       = REG_PASS,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_wen_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              test_done_o,
  output logic              test_pass_o,
  output logic              test_fail_o,
  output logic              test_timeout_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  if ((SETTLE_CYCLES < 1) || (TIMEOUT_CYCLES < 2) ||
      (DONE_REG < 1) || (DONE_REG > 31) ||
      (PASS_REG < 1) || (PASS_REG > 31) || (PASS_REG == DONE_REG)) begin : g_bad_params
    $fatal(1, "riscv_test_monitor: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  mon_state_t       state_q, state_d;
  logic [XLEN-1:0]  done_q, pass_q;
  logic [CNT_W-1:0] cycle_cnt, settle_cnt;
  logic             cyc_en, settle_en, settle_clr;
  logic             latch, pass_d, timeout_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= '0;
      pass_q <= '0;
    end else if (wb_wen_i && (wb_addr_i != 5'd0)) begin
      if (wb_addr_i == 5'(DONE_REG)) done_q <= wb_data_i;
      if (wb_addr_i == 5'(PASS_REG)) pass_q <= wb_data_i;
    end
  end

  mon_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (cyc_en),
    .clr     (1'b0),
    .cnt     (cycle_cnt)
  );

  mon_sat_counter #(.W(CNT_W)) u_settle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (settle_en),
    .clr     (settle_clr),
    .cnt     (settle_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // the cycle counter only advances on edges that stay in RUN, so it freezes at the exit value
  always_comb begin
    state_d    = state_q;
    cyc_en     = 1'b0;
    settle_en  = 1'b0;
    settle_clr = 1'b0;
    latch      = 1'b0;
    pass_d     = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (done_q == 32'd1) begin
          state_d    = ST_SETTLE;
          settle_clr = 1'b1;
        end else if (cycle_cnt == TIMEOUT_LAST) begin
          state_d   = ST_DONE;
          latch     = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cyc_en = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_d = ST_DONE;
          latch   = 1'b1;
          pass_d  = (pass_q == 32'd1);
        end else begin
          settle_en = 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      test_done_o    <= 1'b0;
      test_pass_o    <= 1'b0;
      test_fail_o    <= 1'b0;
      test_timeout_o <= 1'b0;
    end else if (latch) begin
      test_done_o    <= 1'b1;
      test_pass_o    <= pass_d;
      test_fail_o    <= !pass_d && !timeout_d;
      test_timeout_o <= timeout_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb/tb_riscv_test_monitor.sv - directed scoreboard bench for riscv_test_monitor
module tb_riscv_test_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_wen_i = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        test_done_o, test_pass_o, test_fail_o, test_timeout_o;
  logic [31:0] cycle_cnt_o;

  riscv_test_monitor #(
    .SETTLE_CYCLES  (50),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wb_wen_i       (wb_wen_i),
    .wb_addr_i      (wb_addr_i),
    .wb_data_i      (wb_data_i),
    .test_done_o    (test_done_o),
    .test_pass_o    (test_pass_o),
    .test_fail_o    (test_fail_o),
    .test_timeout_o (test_timeout_o),
    .cycle_cnt_o    (cycle_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    done_edge;
    logic  pass;
    logic  fail;
    logic  tmo;
    int    cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_edge = -1;
  bit   seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock; cyc counts edges since reset release, first edge is edge 0
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (test_done_o && !seen) begin
      seen      = 1'b1;
      done_edge = cyc - 1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"}, test_done_o, 0);
    check({tag, "_pass"}, test_pass_o, 0);
    check({tag, "_fail"}, test_fail_o, 0);
    check({tag, "_tmo"},  test_timeout_o, 0);
    check({tag, "_cnt"},  cycle_cnt_o, 0);
  endtask

  // async assertion off the clock edge, outputs must clear before any posedge
  task automatic reset_dut(input string tag);
    #2 reset_n = 1'b0;
    #1 check_zero(tag);
    @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    cyc       = 0;
    seen      = 1'b0;
    done_edge = -1;
  endtask

  task automatic do_write(input int at_edge, input logic [4:0] addr, input logic [31:0] data);
    while (cyc < at_edge) step();
    wb_wen_i  = 1'b1;
    wb_addr_i = addr;
    wb_data_i = data;
    step();
    wb_wen_i  = 1'b0;
    wb_addr_i = '0;
    wb_data_i = '0;
  endtask

  task automatic push_exp(input string tag, input int e, input logic p, input logic f,
                          input logic t, input int c);
    exp_t x;
    x.tag = tag; x.done_edge = e; x.pass = p; x.fail = f; x.tmo = t; x.cnt = c;
    sb.push_back(x);
  endtask

  task automatic collect();
    exp_t x;
    x = sb.pop_front();
    while (!seen && cyc < 400) step();
    check({x.tag, "_done"}, test_done_o, 1);
    check({x.tag, "_edge"}, done_edge, x.done_edge);
    check({x.tag, "_pass"}, test_pass_o, x.pass);
    check({x.tag, "_fail"}, test_fail_o, x.fail);
    check({x.tag, "_tmo"},  test_timeout_o, x.tmo);
    check({x.tag, "_cnt"},  cycle_cnt_o, x.cnt);
    repeat (5) step();
    check({x.tag, "_sticky_done"}, test_done_o, 1);
    check({x.tag, "_sticky_cnt"},  cycle_cnt_o, x.cnt);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_zero("por");
    @(negedge clk);
    reset_n = 1'b1;

    push_exp("pass", 71, 1, 0, 0, 21);
    do_write(10, 27, 1); do_write(20, 26, 1);
    collect();
    reset_dut("rst_after_pass");

    push_exp("fail", 71, 0, 1, 0, 21);
    do_write(10, 27, 0); do_write(20, 26, 1);
    collect();
    reset_dut("rst_after_fail");

    push_exp("timeout", 199, 0, 0, 1, 199);
    do_write(10, 0, 1); do_write(20, 26, 2); do_write(30, 27, 1);
    collect();
    reset_dut("rst_after_tmo");

    push_exp("done_at_limit", 249, 0, 1, 0, 199);
    do_write(198, 26, 1);
    collect();
    reset_dut("rst_after_limit");

    push_exp("done_too_late", 199, 0, 0, 1, 199);
    do_write(199, 26, 1);
    collect();
    reset_dut("rst_after_late");

    push_exp("pass_last_cycle", 71, 0, 1, 0, 21);
    do_write(20, 26, 1); do_write(71, 27, 1);
    collect();
    reset_dut("rst_after_last");

    push_exp("pass_before_last", 71, 1, 0, 0, 21);
    do_write(20, 26, 1); do_write(70, 27, 1);
    collect();
    reset_dut("rst_after_before_last");

    push_exp("pass_value_2", 71, 0, 1, 0, 21);
    do_write(10, 27, 2); do_write(20, 26, 1);
    collect();
    reset_dut("rst_after_val2");

    push_exp("done_sticky", 71, 1, 0, 0, 21);
    do_write(10, 27, 1); do_write(20, 26, 1); do_write(30, 26, 0);
    collect();
    reset_dut("rst_after_sticky");

    do_write(20, 26, 1);
    while (cyc < 40) step();
    check("mid_settle_done", test_done_o, 0);
    check("mid_settle_cnt", cycle_cnt_o, 21);
    reset_dut("rst_mid_settle");

    push_exp("rerun_pass", 71, 1, 0, 0, 21);
    do_write(10, 27, 1); do_write(20, 26, 1);
    collect();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
